// File: rtl/scope_pkg.sv
// Shared types and constants for the oscilloscope acquisition path.
// Column/row widths match the 640x480 trace RAM read by the VGA side.
package scope_pkg;

  localparam int X_W      = 10;
  localparam int Y_W      = 9;
  localparam int H_PIXELS = 640;
  localparam int V_MAX    = 479;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRIME     = 3'd1,
    WAIT_TRIG = 3'd2,
    CAPTURE   = 3'd3,
    HOLDOFF   = 3'd4
  } state_e;

  // Amplitude grows upward, screen rows grow downward; out-of-range samples pin to the top row.
  function automatic logic [Y_W-1:0] sample_to_row(input logic [Y_W-1:0] s,
                                                   input logic [Y_W-1:0] vmax);
    return (s > vmax) ? '0 : (vmax - s);
  endfunction

endpackage

// File: rtl/scope_capture_if.sv
// Sample stream, acquisition controls and trace-RAM write port of scope_capture.
// Inputs are sampled on i_clk; write outputs are registered; dbg_state mirrors the FSM.
interface scope_capture_if;
  import scope_pkg::*;

  logic           i_sample_valid;
  logic [Y_W-1:0] i_sample;
  logic [Y_W-1:0] i_trigger_level;
  logic           i_edge_falling;
  logic [3:0]     i_decim;
  logic           i_arm;
  logic           i_continuous;
  logic           i_auto;
  logic           i_abort;

  logic           o_wr_en;
  logic [X_W-1:0] o_wr_addr;
  logic [Y_W-1:0] o_wr_data;
  logic           o_busy;
  logic           o_triggered;
  logic           o_frame_done;
  state_e         dbg_state;

  modport master (
    output i_sample_valid, i_sample, i_trigger_level, i_edge_falling, i_decim,
           i_arm, i_continuous, i_auto, i_abort,
    input  o_wr_en, o_wr_addr, o_wr_data, o_busy, o_triggered, o_frame_done, dbg_state
  );

  modport slave (
    input  i_sample_valid, i_sample, i_trigger_level, i_edge_falling, i_decim,
           i_arm, i_continuous, i_auto, i_abort,
    output o_wr_en, o_wr_addr, o_wr_data, o_busy, o_triggered, o_frame_done, dbg_state
  );

endinterface

// File: rtl/scope_capture_edge_detect.sv
// Combinational level-crossing compare between two successive samples.
// Equal prev/cur can never hit because one side of each compare is strict.
module edge_detect
  import scope_pkg::*;
(
  input  logic [Y_W-1:0] prev_i,
  input  logic [Y_W-1:0] cur_i,
  input  logic [Y_W-1:0] level_i,
  input  logic           falling_i,
  output logic           hit_o
);

  always_comb begin
    hit_o = 1'b0;
    if (falling_i) begin
      hit_o = (prev_i >= level_i) && (cur_i < level_i);
    end else begin
      hit_o = (prev_i < level_i) && (cur_i >= level_i);
    end
  end

endmodule

// File: rtl/scope_capture.sv
// Trigger/decimate/capture writer: fills one trace line of H_PIXELS columns per trigger.
// Writes land one cycle after the accepted sample; abort and reset drop any pending write.
module scope_capture #(
  parameter int H_PIXELS       = scope_pkg::H_PIXELS,
  parameter int V_MAX          = scope_pkg::V_MAX,
  parameter int HOLDOFF_CYCLES = 1000,
  parameter int AUTO_TIMEOUT   = 4096
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  scope_capture_if.slave  bus
);
  import scope_pkg::X_W;
  import scope_pkg::Y_W;
  import scope_pkg::state_e;
  import scope_pkg::IDLE;
  import scope_pkg::PRIME;
  import scope_pkg::WAIT_TRIG;
  import scope_pkg::CAPTURE;
  import scope_pkg::HOLDOFF;
  import scope_pkg::sample_to_row;

  localparam int TMO_W = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
  localparam int HLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  localparam logic [X_W-1:0]   X_LAST   = X_W'(H_PIXELS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(AUTO_TIMEOUT - 1);
  localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLDOFF_CYCLES - 1);
  localparam logic [Y_W-1:0]   V_MAX_Y  = Y_W'(V_MAX);

  state_e           state_q,   state_d;
  logic [3:0]       decim_q,   decim_d;
  logic [3:0]       dcnt_q,    dcnt_d;
  logic [X_W-1:0]   x_q,       x_d;
  logic [Y_W-1:0]   prev_q,    prev_d;
  logic [TMO_W-1:0] tmo_q,     tmo_d;
  logic [HLD_W-1:0] hld_q,     hld_d;
  logic             wr_en_q,   wr_en_d;
  logic [X_W-1:0]   wr_addr_q, wr_addr_d;
  logic [Y_W-1:0]   wr_data_q, wr_data_d;
  logic             trig_q,    trig_d;
  logic             done_q,    done_d;

  logic           sampling;
  logic           accept;
  logic           hit;
  logic           fire;
  logic [Y_W-1:0] row;

  edge_detect u_edge_detect (
    .prev_i    (prev_q),
    .cur_i     (bus.i_sample),
    .level_i   (bus.i_trigger_level),
    .falling_i (bus.i_edge_falling),
    .hit_o     (hit)
  );

  // The decimator only runs while samples matter; HOLDOFF and IDLE ignore the stream.
  assign sampling = (state_q == PRIME) || (state_q == WAIT_TRIG) || (state_q == CAPTURE);
  assign accept   = sampling && bus.i_sample_valid && (dcnt_q == '0);
  assign fire     = hit || (bus.i_auto && (tmo_q == TMO_LAST));
  assign row      = sample_to_row(bus.i_sample, V_MAX_Y);

  always_comb begin
    state_d   = state_q;
    decim_d   = decim_q;
    dcnt_d    = dcnt_q;
    x_d       = x_q;
    prev_d    = prev_q;
    tmo_d     = tmo_q;
    hld_d     = hld_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    trig_d    = 1'b0;
    done_d    = 1'b0;

    if (sampling && bus.i_sample_valid) begin
      dcnt_d = (dcnt_q == '0) ? decim_q : (dcnt_q - 4'd1);
    end

    unique case (state_q)
      IDLE: begin
        if (bus.i_arm) begin
          decim_d = bus.i_decim;
          dcnt_d  = '0;
          tmo_d   = '0;
          x_d     = '0;
          state_d = PRIME;
        end
      end
      PRIME: begin
        if (accept) begin
          prev_d  = bus.i_sample;
          tmo_d   = '0;
          state_d = WAIT_TRIG;
        end
      end
      WAIT_TRIG: begin
        if (accept) begin
          prev_d = bus.i_sample;
          if (fire) begin
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            wr_data_d = row;
            trig_d    = 1'b1;
            x_d       = X_W'(1);
            state_d   = CAPTURE;
          end else if (tmo_q != TMO_LAST) begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      CAPTURE: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = x_q;
          wr_data_d = row;
          if (x_q == X_LAST) begin
            done_d  = 1'b1;
            x_d     = '0;
            hld_d   = '0;
            state_d = bus.i_continuous ? HOLDOFF : IDLE;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      HOLDOFF: begin
        // Re-prime with a fresh decimation phase; the latched ratio is kept.
        if (hld_q == HLD_LAST) begin
          hld_d   = '0;
          dcnt_d  = '0;
          tmo_d   = '0;
          state_d = PRIME;
        end else begin
          hld_d = hld_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.i_abort) begin
      state_d = IDLE;
      wr_en_d = 1'b0;
      trig_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      decim_q   <= '0;
      dcnt_q    <= '0;
      x_q       <= '0;
      prev_q    <= '0;
      tmo_q     <= '0;
      hld_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      trig_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      decim_q   <= decim_d;
      dcnt_q    <= dcnt_d;
      x_q       <= x_d;
      prev_q    <= prev_d;
      tmo_q     <= tmo_d;
      hld_q     <= hld_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      trig_q    <= trig_d;
      done_q    <= done_d;
    end
  end

  assign bus.o_wr_en      = wr_en_q;
  assign bus.o_wr_addr    = wr_addr_q;
  assign bus.o_wr_data    = wr_data_q;
  assign bus.o_triggered  = trig_q;
  assign bus.o_frame_done = done_q;
  assign bus.o_busy       = (state_q != IDLE);
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_scope_capture.sv
// Directed bench for scope_capture: stimulus pushes expected trace writes (with their
// due cycle) into a queue, a monitor pops and compares every write the DUT makes.
module tb_scope_capture;
  import scope_pkg::*;

  localparam int AUTO_TO = 16;
  localparam int HOLD    = 1000;
  localparam int REC_W   = 32 + X_W + Y_W + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  logic [REC_W-1:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  scope_capture_if bus ();

  scope_capture #(
    .H_PIXELS       (H_PIXELS),
    .V_MAX          (V_MAX),
    .HOLDOFF_CYCLES (HOLD),
    .AUTO_TIMEOUT   (AUTO_TO)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int s);
    bus.i_sample       = Y_W'(s);
    bus.i_sample_valid = 1'b1;
    tick();
    bus.i_sample_valid = 1'b0;
  endtask

  task automatic arm();
    bus.i_arm = 1'b1;
    tick();
    bus.i_arm = 1'b0;
  endtask

  task automatic abort();
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
  endtask

  task automatic setup(input bit falling, input int level, input int decim, input bit cont,
                       input bit auto_en);
    bus.i_edge_falling  = falling;
    bus.i_trigger_level = Y_W'(level);
    bus.i_decim         = 4'(decim);
    bus.i_continuous    = cont;
    bus.i_auto          = auto_en;
  endtask

  // Expected write produced by the sample driven in the current cycle.
  task automatic expect_write(input int x, input int d, input bit t, input bit dn);
    exp_q.push_back({32'(cyc + 1), X_W'(x), Y_W'(d), t, dn});
  endtask

  function automatic int row_of(input int v);
    return (v > 479) ? 0 : 479 - v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic monitor();
    logic [REC_W-1:0] got;
    logic [REC_W-1:0] want;
    forever begin
      @(negedge clk);
      if (bus.o_wr_en === 1'b1) begin
        tests++;
        got = {32'(cyc), bus.o_wr_addr, bus.o_wr_data, bus.o_triggered, bus.o_frame_done};
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: got x=%0d d=%0d at cycle %0d, expected no write",
                   bus.o_wr_addr, bus.o_wr_data, cyc);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            fails++;
            $display("FAIL write_record: got cyc=%0d x=%0d d=%0d trg=%0b done=%0b, expected cyc=%0d x=%0d d=%0d trg=%0b done=%0b",
                     got[52:21], got[20:11], got[10:2], got[1], got[0],
                     want[52:21], want[20:11], want[10:2], want[1], want[0]);
          end
        end
      end else if (bus.o_triggered !== 1'b0 || bus.o_frame_done !== 1'b0) begin
        tests++;
        fails++;
        $display("FAIL stray_pulse: got trg=%0b done=%0b without write, expected 0 0",
                 bus.o_triggered, bus.o_frame_done);
      end
    end
  endtask

  // ---------------- directed tests ----------------
  task automatic test_rising_single();
    int s;
    setup(1'b0, 200, 0, 1'b0, 1'b0);
    arm();
    check("t1_state_prime", int'(bus.dbg_state), int'(PRIME));
    for (int k = 0; k <= 665; k++) begin
      s = (k * 10) % 480;
      if (k >= 20 && k <= 659) expect_write(k - 20, row_of(s), k == 20, k == 659);
      send(s);
    end
    check("t1_busy_after", int'(bus.o_busy), 0);
    check("t1_state_idle", int'(bus.dbg_state), int'(IDLE));
    check("t1_all_written", exp_q.size(), 0);
  endtask

  task automatic test_falling();
    setup(1'b1, 100, 0, 1'b0, 1'b0);
    arm();
    send(150);
    send(120);
    send(100);
    check("t2_no_trig_on_equal", int'(bus.dbg_state), int'(WAIT_TRIG));
    expect_write(0, 380, 1'b1, 1'b0);
    send(99);
    expect_write(1, 381, 1'b0, 1'b0);
    send(98);
    check("t2_state_capture", int'(bus.dbg_state), int'(CAPTURE));
    abort();
    check("t2_state_idle", int'(bus.dbg_state), int'(IDLE));
    check("t2_busy", int'(bus.o_busy), 0);
  endtask

  task automatic test_decim();
    int s;
    setup(1'b0, 200, 3, 1'b0, 1'b0);
    arm();
    bus.i_decim = 4'd0;  // latched on arm, so this must not matter
    for (int k = 0; k <= 723; k++) begin
      s = (k > 500) ? 500 : k;
      if (k >= 200 && (k % 4) == 0) expect_write((k - 200) / 4, row_of(s), k == 200, 1'b0);
      send(s);
      if ((k % 7) == 3) tick();
    end
    abort();
    check("t3_state_idle", int'(bus.dbg_state), int'(IDLE));
  endtask

  task automatic test_auto();
    setup(1'b0, 300, 0, 1'b0, 1'b1);
    arm();
    send(50);
    for (int i = 1; i <= AUTO_TO; i++) begin
      if (i == AUTO_TO) expect_write(0, 429, 1'b1, 1'b0);
      send(50);
    end
    check("t4_auto_capture", int'(bus.dbg_state), int'(CAPTURE));
    abort();
    bus.i_auto = 1'b0;
    arm();
    for (int i = 0; i < 40; i++) send(50);
    check("t4_noauto_wait", int'(bus.dbg_state), int'(WAIT_TRIG));
    arm();
    check("t4_arm_ignored", int'(bus.dbg_state), int'(WAIT_TRIG));
    check("t4_busy", int'(bus.o_busy), 1);
    // Live level: prev 50 < 51 and cur 60 >= 51
    bus.i_trigger_level = 9'd51;
    expect_write(0, 419, 1'b1, 1'b0);
    send(60);
    abort();
    bus.i_arm = 1'b1;
    bus.i_abort = 1'b1;
    tick();
    bus.i_arm = 1'b0;
    bus.i_abort = 1'b0;
    check("t4_abort_beats_arm", int'(bus.dbg_state), int'(IDLE));
  endtask

  task automatic test_continuous();
    int s;
    setup(1'b0, 200, 0, 1'b1, 1'b0);
    arm();
    // Holdoff ignores k=660..1659; k=1660 (280) primes; next 190->200 crossing is k=1700.
    for (int k = 0; k <= 1710; k++) begin
      s = (k * 10) % 480;
      if (k >= 20 && k <= 659) expect_write(k - 20, row_of(s), k == 20, k == 659);
      if (k >= 1700) expect_write(k - 1700, row_of(s), k == 1700, 1'b0);
      send(s);
      if (k == 661 || k == 1100 || k == 1658) begin
        check("t5_holdoff_state", int'(bus.dbg_state), int'(HOLDOFF));
        check("t5_holdoff_busy", int'(bus.o_busy), 1);
      end
    end
    check("t5_frame2_capture", int'(bus.dbg_state), int'(CAPTURE));
    abort();
    bus.i_continuous = 1'b0;
  endtask

  task automatic test_abort_reset();
    int s;
    setup(1'b0, 200, 0, 1'b0, 1'b0);
    arm();
    for (int k = 0; k < 320; k++) begin
      s = (k * 10) % 480;
      if (k >= 20) expect_write(k - 20, row_of(s), k == 20, 1'b0);
      send(s);
    end
    bus.i_abort = 1'b1;
    send(320);
    bus.i_abort = 1'b0;
    check("t6_abort_idle", int'(bus.dbg_state), int'(IDLE));
    for (int k = 321; k < 340; k++) send((k * 10) % 480);
    check("t6_abort_busy", int'(bus.o_busy), 0);

    arm();
    for (int k = 0; k < 320; k++) begin
      s = (k * 10) % 480;
      if (k >= 20) expect_write(k - 20, row_of(s), k == 20, 1'b0);
      send(s);
    end
    rst_n = 1'b0;
    send(320);
    check("t6_rst_wr_en", int'(bus.o_wr_en), 0);
    check("t6_rst_addr", int'(bus.o_wr_addr), 0);
    check("t6_rst_data", int'(bus.o_wr_data), 0);
    check("t6_rst_trig", int'(bus.o_triggered), 0);
    check("t6_rst_done", int'(bus.o_frame_done), 0);
    check("t6_rst_busy", int'(bus.o_busy), 0);
    check("t6_rst_state", int'(bus.dbg_state), int'(IDLE));
    rst_n = 1'b1;
    for (int k = 321; k < 340; k++) send((k * 10) % 480);

    arm();
    for (int k = 0; k <= 30; k++) begin
      s = (k * 10) % 480;
      if (k >= 20) expect_write(k - 20, row_of(s), k == 20, 1'b0);
      send(s);
    end
    abort();
  endtask

  // ---------------- clock/reset and sequencing ----------------
  initial begin
    bus.i_sample_valid  = 1'b0;
    bus.i_sample        = '0;
    bus.i_trigger_level = '0;
    bus.i_edge_falling  = 1'b0;
    bus.i_decim         = '0;
    bus.i_arm           = 1'b0;
    bus.i_continuous    = 1'b0;
    bus.i_auto          = 1'b0;
    bus.i_abort         = 1'b0;
    fork
      monitor();
    join_none
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_wr_en", int'(bus.o_wr_en), 0);
    check("reset_addr", int'(bus.o_wr_addr), 0);
    check("reset_data", int'(bus.o_wr_data), 0);
    check("reset_busy", int'(bus.o_busy), 0);
    check("reset_trig", int'(bus.o_triggered), 0);
    check("reset_done", int'(bus.o_frame_done), 0);
    check("reset_state", int'(bus.dbg_state), int'(IDLE));
    rst_n = 1'b1;
    tick();

    test_rising_single();
    test_falling();
    test_decim();
    test_auto();
    test_continuous();
    test_abort_reset();

    repeat (4) tick();
    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
